// File: rtl/io_fifo_bank_if.sv
// Core read/write port and per-channel device streams of io_fifo_bank.
// The bank connects as slave; the core and device side together act as master.
interface io_fifo_bank_if #(
  parameter int unsigned D_WIDTH  = 34,
  parameter int unsigned PA_WIDTH = 4,
  parameter int unsigned NUM_CH   = 4
);
  logic                      read_req_i;
  logic [PA_WIDTH-1:0]       read_addr_i;
  logic [D_WIDTH-1:0]        dout_o;
  logic                      read_ack_o;
  logic                      write_req_i;
  logic [PA_WIDTH-1:0]       write_addr_i;
  logic [D_WIDTH-1:0]        din_i;
  logic                      write_ack_o;
  logic [NUM_CH-1:0]         ext_in_valid_i;
  logic [NUM_CH*D_WIDTH-1:0] ext_in_data_i;
  logic [NUM_CH-1:0]         ext_in_ready_o;
  logic [NUM_CH-1:0]         ext_out_valid_o;
  logic [NUM_CH*D_WIDTH-1:0] ext_out_data_o;
  logic [NUM_CH-1:0]         ext_out_ready_i;

  modport master (
    output read_req_i, read_addr_i, write_req_i, write_addr_i, din_i,
           ext_in_valid_i, ext_in_data_i, ext_out_ready_i,
    input  dout_o, read_ack_o, write_ack_o, ext_in_ready_o,
           ext_out_valid_o, ext_out_data_o
  );

  modport slave (
    input  read_req_i, read_addr_i, write_req_i, write_addr_i, din_i,
           ext_in_valid_i, ext_in_data_i, ext_out_ready_i,
    output dout_o, read_ack_o, write_ack_o, ext_in_ready_o,
           ext_out_valid_o, ext_out_data_o
  );
endinterface

// File: rtl/io_fifo_bank.sv
// Bank of per-channel in/out FIFOs between a req/ack core port and valid/ready devices.
// Address NUM_CH is a status word; higher addresses read zero and swallow writes.
module io_fifo_bank #(
  parameter int unsigned D_WIDTH  = 34,
  parameter int unsigned PA_WIDTH = 4,
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DEPTH    = 8
) (
  input  logic          clk,
  input  logic          reset_i,
  io_fifo_bank_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ACK = 2'd1, R_DROP = 2'd2} rd_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ACK = 2'd1, W_DROP = 2'd2} wr_state_e;

  rd_state_e           rd_state_q, rd_state_d;
  wr_state_e           wr_state_q, wr_state_d;
  logic                read_ack_q, read_ack_d;
  logic                write_ack_q, write_ack_d;
  logic [D_WIDTH-1:0]  dout_q, dout_d;

  logic [D_WIDTH-1:0]  in_mem_q  [NUM_CH][DEPTH];
  logic [D_WIDTH-1:0]  out_mem_q [NUM_CH][DEPTH];
  logic [PW-1:0]       in_wp_q  [NUM_CH], in_wp_d  [NUM_CH];
  logic [PW-1:0]       in_rp_q  [NUM_CH], in_rp_d  [NUM_CH];
  logic [PW-1:0]       out_wp_q [NUM_CH], out_wp_d [NUM_CH];
  logic [PW-1:0]       out_rp_q [NUM_CH], out_rp_d [NUM_CH];
  logic [CW-1:0]       in_cnt_q  [NUM_CH], in_cnt_d  [NUM_CH];
  logic [CW-1:0]       out_cnt_q [NUM_CH], out_cnt_d [NUM_CH];
  logic [NUM_CH-1:0]   in_ready_q, in_ready_d;
  logic [NUM_CH-1:0]   out_valid_q, out_valid_d;

  logic [NUM_CH-1:0]   in_push, in_pop, out_push, out_pop;
  logic [NUM_CH-1:0]   rd_hit, wr_hit;
  logic                rd_ok, wr_ok;
  logic [D_WIDTH-1:0]  rd_data, status;
  logic [NUM_CH*D_WIDTH-1:0] ext_out_data_c;

  // Status word: input non-empty flags low, output full flags above them.
  always_comb begin : status_word
    status = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      status[c]          = (in_cnt_q[c] != '0);
      status[NUM_CH + c] = (out_cnt_q[c] == CW'(DEPTH));
    end
  end

  always_comb begin : rd_select
    rd_ok   = 1'b1;
    rd_hit  = '0;
    rd_data = '0;
    if (bus.read_addr_i == PA_WIDTH'(NUM_CH)) rd_data = status;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.read_addr_i == PA_WIDTH'(c)) begin
        rd_hit[c] = 1'b1;
        rd_ok     = (in_cnt_q[c] != '0);
        rd_data   = in_mem_q[c][in_rp_q[c]];
      end
    end
  end

  always_comb begin : wr_select
    wr_ok  = 1'b1;
    wr_hit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.write_addr_i == PA_WIDTH'(c)) begin
        wr_hit[c] = 1'b1;
        wr_ok     = (out_cnt_q[c] != CW'(DEPTH));
      end
    end
  end

  // Read handshake: one-cycle ack, then wait for the request to drop.
  always_comb begin : rd_fsm
    rd_state_d = rd_state_q;
    read_ack_d = 1'b0;
    dout_d     = dout_q;
    in_pop     = '0;
    unique case (rd_state_q)
      R_IDLE: begin
        if (bus.read_req_i && rd_ok) begin
          rd_state_d = R_ACK;
          read_ack_d = 1'b1;
          dout_d     = rd_data;
          in_pop     = rd_hit;
        end
      end
      R_ACK:   rd_state_d = R_DROP;
      R_DROP:  if (!bus.read_req_i) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin : wr_fsm
    wr_state_d  = wr_state_q;
    write_ack_d = 1'b0;
    out_push    = '0;
    unique case (wr_state_q)
      W_IDLE: begin
        if (bus.write_req_i && wr_ok) begin
          wr_state_d  = W_ACK;
          write_ack_d = 1'b1;
          out_push    = wr_hit;
        end
      end
      W_ACK:   wr_state_d = W_DROP;
      W_DROP:  if (!bus.write_req_i) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Pointer/count bookkeeping; flags are registered from the next counts.
  always_comb begin : fifo_next
    in_push = '0;
    out_pop = '0;
    in_ready_d  = '0;
    out_valid_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      in_push[c]   = bus.ext_in_valid_i[c] && in_ready_q[c];
      out_pop[c]   = out_valid_q[c] && bus.ext_out_ready_i[c];
      in_wp_d[c]   = in_wp_q[c]  + (in_push[c]  ? PW'(1) : PW'(0));
      in_rp_d[c]   = in_rp_q[c]  + (in_pop[c]   ? PW'(1) : PW'(0));
      out_wp_d[c]  = out_wp_q[c] + (out_push[c] ? PW'(1) : PW'(0));
      out_rp_d[c]  = out_rp_q[c] + (out_pop[c]  ? PW'(1) : PW'(0));
      in_cnt_d[c]  = in_cnt_q[c]  + CW'(in_push[c])  - CW'(in_pop[c]);
      out_cnt_d[c] = out_cnt_q[c] + CW'(out_push[c]) - CW'(out_pop[c]);
      in_ready_d[c]  = (in_cnt_d[c] != CW'(DEPTH));
      out_valid_d[c] = (out_cnt_d[c] != '0);
    end
  end

  always_ff @(posedge clk) begin : state_regs
    if (reset_i) begin
      rd_state_q  <= R_IDLE;
      wr_state_q  <= W_IDLE;
      read_ack_q  <= 1'b0;
      write_ack_q <= 1'b0;
      dout_q      <= '0;
      in_ready_q  <= '1;
      out_valid_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        in_wp_q[c]   <= '0;
        in_rp_q[c]   <= '0;
        out_wp_q[c]  <= '0;
        out_rp_q[c]  <= '0;
        in_cnt_q[c]  <= '0;
        out_cnt_q[c] <= '0;
      end
    end else begin
      rd_state_q  <= rd_state_d;
      wr_state_q  <= wr_state_d;
      read_ack_q  <= read_ack_d;
      write_ack_q <= write_ack_d;
      dout_q      <= dout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      for (int c = 0; c < NUM_CH; c++) begin
        in_wp_q[c]   <= in_wp_d[c];
        in_rp_q[c]   <= in_rp_d[c];
        out_wp_q[c]  <= out_wp_d[c];
        out_rp_q[c]  <= out_rp_d[c];
        in_cnt_q[c]  <= in_cnt_d[c];
        out_cnt_q[c] <= out_cnt_d[c];
      end
    end
  end

  // Storage needs no reset: nothing is visible until a count says so.
  always_ff @(posedge clk) begin : fifo_mem
    for (int c = 0; c < NUM_CH; c++) begin
      if (in_push[c])  in_mem_q[c][in_wp_q[c]]   <= bus.ext_in_data_i[c*D_WIDTH +: D_WIDTH];
      if (out_push[c]) out_mem_q[c][out_wp_q[c]] <= bus.din_i;
    end
  end

  always_comb begin : out_head
    ext_out_data_c = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ext_out_data_c[c*D_WIDTH +: D_WIDTH] = out_mem_q[c][out_rp_q[c]];
    end
  end

  assign bus.dout_o          = dout_q;
  assign bus.read_ack_o      = read_ack_q;
  assign bus.write_ack_o     = write_ack_q;
  assign bus.ext_in_ready_o  = in_ready_q;
  assign bus.ext_out_valid_o = out_valid_q;
  assign bus.ext_out_data_o  = ext_out_data_c;

endmodule

// File: tb/tb_io_fifo_bank.sv
// Bench for io_fifo_bank: directed scenarios plus random traffic against a queue-based model.
module tb_io_fifo_bank;
  localparam int unsigned DW  = 34;
  localparam int unsigned PAW = 4;
  localparam int unsigned NCH = 4;
  localparam int unsigned DEP = 8;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  io_fifo_bank_if #(.D_WIDTH(DW), .PA_WIDTH(PAW), .NUM_CH(NCH)) bus ();

  io_fifo_bank #(.D_WIDTH(DW), .PA_WIDTH(PAW), .NUM_CH(NCH), .DEPTH(DEP)) dut (
    .clk     (clk),
    .reset_i (reset_i),
    .bus     (bus.slave)
  );

  // Reference model: plain queues plus request bookkeeping.
  logic [DW-1:0] in_q  [NCH][$];
  logic [DW-1:0] out_q [NCH][$];
  bit            rd_locked, wr_locked, exp_rd_ack, exp_wr_ack, dout_zero;
  logic [DW-1:0] exp_dout;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_status();
    logic [DW-1:0] s;
    s = '0;
    for (int c = 0; c < NCH; c++) begin
      s[c]       = (in_q[c].size() != 0);
      s[NCH + c] = (out_q[c].size() == DEP);
    end
    return s;
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    return DW'({$urandom(), $urandom()});
  endfunction

  function automatic logic [PAW-1:0] rnd_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r <= int'(NCH)) return PAW'(r);
    return PAW'($urandom_range(5, 15));
  endfunction

  task automatic compare();
    logic [NCH-1:0] er, ev;
    for (int c = 0; c < NCH; c++) begin
      er[c] = (in_q[c].size() < DEP);
      ev[c] = (out_q[c].size() > 0);
    end
    chk("in_ready", 64'(bus.ext_in_ready_o), 64'(er));
    chk("out_valid", 64'(bus.ext_out_valid_o), 64'(ev));
    for (int c = 0; c < NCH; c++)
      if (ev[c]) chk("out_data", 64'(bus.ext_out_data_o[c*DW +: DW]), 64'(out_q[c][0]));
    chk("rd_ack", 64'(bus.read_ack_o), 64'(exp_rd_ack));
    chk("wr_ack", 64'(bus.write_ack_o), 64'(exp_wr_ack));
    if (exp_rd_ack || dout_zero) chk("dout", 64'(bus.dout_o), 64'(exp_dout));
  endtask

  // Advance one clock: model consumes the inputs currently driven, then outputs are compared.
  task automatic step();
    logic [DW-1:0] st, rd_val;
    int  ra, wa;
    bit  rd_fire, wr_fire;
    bit  in_acc [NCH];
    bit  out_take [NCH];
    st = model_status();
    ra = int'(bus.read_addr_i);
    wa = int'(bus.write_addr_i);
    rd_fire = 1'b0;
    wr_fire = 1'b0;
    rd_val  = '0;
    if (reset_i) begin
      for (int c = 0; c < NCH; c++) begin
        in_q[c].delete();
        out_q[c].delete();
      end
      rd_locked = 0; wr_locked = 0; exp_rd_ack = 0; exp_wr_ack = 0;
      exp_dout = '0; dout_zero = 1;
    end else begin
      if (!exp_rd_ack) begin
        if (rd_locked) begin
          if (!bus.read_req_i) rd_locked = 0;
        end else if (bus.read_req_i) begin
          if (ra < int'(NCH)) begin
            if (in_q[ra].size() > 0) begin rd_fire = 1; rd_val = in_q[ra][0]; end
          end else begin
            rd_fire = 1;
            rd_val  = (ra == int'(NCH)) ? st : '0;
          end
        end
      end
      if (!exp_wr_ack) begin
        if (wr_locked) begin
          if (!bus.write_req_i) wr_locked = 0;
        end else if (bus.write_req_i) begin
          wr_fire = (wa < int'(NCH)) ? (out_q[wa].size() < DEP) : 1'b1;
        end
      end
      for (int c = 0; c < NCH; c++) begin
        in_acc[c]   = bus.ext_in_valid_i[c] && (in_q[c].size() < DEP);
        out_take[c] = bus.ext_out_ready_i[c] && (out_q[c].size() > 0);
      end
      if (rd_fire && ra < int'(NCH)) void'(in_q[ra].pop_front());
      for (int c = 0; c < NCH; c++) begin
        if (out_take[c]) void'(out_q[c].pop_front());
        if (in_acc[c]) in_q[c].push_back(bus.ext_in_data_i[c*DW +: DW]);
      end
      if (wr_fire && wa < int'(NCH)) out_q[wa].push_back(bus.din_i);
      exp_rd_ack = rd_fire;
      exp_wr_ack = wr_fire;
      if (rd_fire) begin rd_locked = 1; exp_dout = rd_val; dout_zero = 0; end
      if (wr_fire) wr_locked = 1;
    end
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
  endtask

  task automatic ext_push(input int c, input logic [DW-1:0] d);
    bus.ext_in_valid_i[c] = 1'b1;
    bus.ext_in_data_i[c*DW +: DW] = d;
    step();
    bus.ext_in_valid_i[c] = 1'b0;
  endtask

  task automatic wait_rd(input string tag, input logic [DW-1:0] exp);
    bit got;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (bus.read_ack_o) begin
        got = 1;
        chk({tag, "_data"}, 64'(bus.dout_o), 64'(exp));
      end
    end
    chk({tag, "_ack"}, 64'(got), 64'(1));
  endtask

  task automatic core_read(input logic [PAW-1:0] a, input logic [DW-1:0] exp, input string tag);
    bus.read_req_i  = 1'b1;
    bus.read_addr_i = a;
    wait_rd(tag, exp);
    bus.read_req_i = 1'b0;
    step();
    step();
  endtask

  task automatic core_write(input logic [PAW-1:0] a, input logic [DW-1:0] d, input string tag);
    bit got;
    got = 0;
    bus.write_req_i  = 1'b1;
    bus.write_addr_i = a;
    bus.din_i        = d;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (bus.write_ack_o) got = 1;
    end
    chk({tag, "_ack"}, 64'(got), 64'(1));
    bus.write_req_i = 1'b0;
    step();
    step();
  endtask

  initial begin
    reset_i = 1'b1;
    bus.read_req_i = 0; bus.read_addr_i = '0;
    bus.write_req_i = 0; bus.write_addr_i = '0; bus.din_i = '0;
    bus.ext_in_valid_i = '0; bus.ext_in_data_i = '0; bus.ext_out_ready_i = '0;
    do_reset();
    chk("rst_in_ready", 64'(bus.ext_in_ready_o), 64'(4'hF));
    chk("rst_dout", 64'(bus.dout_o), 64'(0));

    // Two words through ch1 in order, then FIFO empty.
    ext_push(1, 34'h1);
    ext_push(1, 34'h2);
    core_read(4'd1, 34'h1, "s1_rd0");
    core_read(4'd1, 34'h2, "s1_rd1");
    core_read(4'd4, 34'h0, "s1_status");

    // Read of empty ch2 stalls until data arrives.
    bus.read_req_i = 1; bus.read_addr_i = 4'd2;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("s2_stall", 64'(bus.read_ack_o), 64'(0));
    end
    bus.ext_in_valid_i[2] = 1'b1;
    bus.ext_in_data_i[2*DW +: DW] = 34'h3AB;
    step();
    bus.ext_in_valid_i[2] = 1'b0;
    chk("s2_push_edge", 64'(bus.read_ack_o), 64'(0));
    step();
    chk("s2_ack", 64'(bus.read_ack_o), 64'(1));
    chk("s2_data", 64'(bus.dout_o), 64'(34'h3AB));
    bus.read_req_i = 0;
    step(); step();

    // Fill ch0 output FIFO, stall, release one slot.
    for (int i = 0; i < int'(DEP); i++) core_write(4'd0, DW'(i + 16), "s3_fill");
    bus.write_req_i = 1; bus.write_addr_i = 4'd0; bus.din_i = 34'h99;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("s3_full_stall", 64'(bus.write_ack_o), 64'(0));
    end
    chk("s3_head", 64'(bus.ext_out_data_o[DW-1:0]), 64'(16));
    bus.ext_out_ready_i[0] = 1'b1;
    step();
    bus.ext_out_ready_i[0] = 1'b0;
    chk("s3_drain_edge", 64'(bus.write_ack_o), 64'(0));
    step();
    chk("s3_late_ack", 64'(bus.write_ack_o), 64'(1));
    bus.write_req_i = 0;
    step(); step();
    bus.ext_out_ready_i[0] = 1'b1;
    for (int i = 0; i < 10; i++) step();
    bus.ext_out_ready_i[0] = 1'b0;
    chk("s3_drained", 64'(bus.ext_out_valid_o[0]), 64'(0));

    // Status: ch0 in non-empty, ch3 out full.
    do_reset();
    ext_push(0, 34'h55);
    for (int i = 0; i < int'(DEP); i++) core_write(4'd3, DW'(i), "s4_fill");
    core_read(4'd4, 34'h81, "s4_status");

    // Held request gives exactly one ack/pop; out-of-range write is swallowed.
    do_reset();
    ext_push(1, 34'hA1); ext_push(1, 34'hA2); ext_push(1, 34'hA3);
    bus.read_req_i = 1; bus.read_addr_i = 4'd1;
    wait_rd("s5_first", 34'hA1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("s5_held", 64'(bus.read_ack_o), 64'(0));
    end
    bus.read_req_i = 0;
    step(); step();
    core_read(4'd1, 34'hA2, "s5_next");
    core_write(4'd15, 34'h123, "s5_wr15");
    core_read(4'd4, 34'h2, "s5_status");

    // Reset during the ack cycle, request still held afterwards.
    do_reset();
    ext_push(2, 34'h11); ext_push(2, 34'h12); ext_push(2, 34'h13);
    bus.read_req_i = 1; bus.read_addr_i = 4'd2;
    wait_rd("s6_pre", 34'h11);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk("s6_ack", 64'(bus.read_ack_o), 64'(0));
    chk("s6_ready", 64'(bus.ext_in_ready_o), 64'(4'hF));
    chk("s6_valid", 64'(bus.ext_out_valid_o), 64'(0));
    step();
    chk("s6_empty_stall", 64'(bus.read_ack_o), 64'(0));
    bus.read_req_i = 0;
    step(); step();
    core_read(4'd4, 34'h0, "s6_status");

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < int'(NCH); c++) begin
        bus.ext_in_valid_i[c] = ($urandom_range(0, 2) == 0);
        bus.ext_in_data_i[c*DW +: DW] = rnd_word();
        bus.ext_out_ready_i[c] = ($urandom_range(0, 3) == 0);
      end
      if (!bus.read_req_i) begin
        if ($urandom_range(0, 2) == 0) begin bus.read_req_i = 1; bus.read_addr_i = rnd_addr(); end
      end else if (rd_locked) begin
        if ($urandom_range(0, 1) == 0) bus.read_req_i = 0;
      end else if ($urandom_range(0, 7) == 0) bus.read_addr_i = rnd_addr();
      if (!bus.write_req_i) begin
        if ($urandom_range(0, 1) == 0) begin
          bus.write_req_i = 1; bus.write_addr_i = rnd_addr(); bus.din_i = rnd_word();
        end
      end else if (wr_locked) begin
        if ($urandom_range(0, 1) == 0) bus.write_req_i = 0;
      end else if ($urandom_range(0, 7) == 0) begin
        bus.write_addr_i = rnd_addr(); bus.din_i = rnd_word();
      end
      reset_i = (n % 500 == 499);
      step();
    end
    reset_i = 1'b0;

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/io_fifo_bank.md
IO_FIFO_BANK -- requirements
Module: io_fifo_bank

Interface
REQ-001 SHALL have parameter D_WIDTH, default 34, meaning data word width in bits.
REQ-002 SHALL have parameter PA_WIDTH, default 4, meaning port address width in bits.
REQ-003 SHALL have parameter NUM_CH, default 4, meaning channel count (1..2**PA_WIDTH-1).
REQ-004 SHALL have parameter DEPTH, default 8, meaning per-FIFO entry count (power of two, >=2).
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  in  1  sole clock, all state updates on its rising edge.
REQ-006 SHALL have reset_i  in  1  synchronous active-high reset.
REQ-007 SHALL have read_req_i  in  1  core read request, held until acked; read_addr_i  in  PA_WIDTH  read port address.
REQ-008 SHALL have dout_o  out  D_WIDTH  read data, valid while read_ack_o=1; read_ack_o  out  1  single-cycle read acknowledge.
REQ-009 SHALL have write_req_i  in  1  core write request, held until acked; write_addr_i  in  PA_WIDTH  write port address; din_i  in  D_WIDTH  write data.
REQ-010 SHALL have write_ack_o  out  1  single-cycle write acknowledge.
REQ-011 SHALL have ext_in_valid_i  in  NUM_CH, ext_in_data_i  in  NUM_CH*D_WIDTH (channel c at bits [c*D_WIDTH +: D_WIDTH]), ext_in_ready_o  out  NUM_CH: device-to-core valid/ready push per channel.
REQ-012 SHALL have ext_out_valid_o  out  NUM_CH, ext_out_data_o  out  NUM_CH*D_WIDTH, ext_out_ready_i  in  NUM_CH: core-to-device valid/ready drain per channel.

Function
REQ-013 SHALL contain, per channel, an input FIFO (ext to core) and an output FIFO (core to ext), each DEPTH entries, count width clog2(DEPTH)+1, pointers wrap modulo DEPTH.
REQ-014 SHALL assert ext_in_ready_o[c] iff input FIFO c not full; push occurs when valid&ready.
REQ-015 SHALL assert ext_out_valid_o[c] iff output FIFO c not empty, ext_out_data_o[c] = its head (first-word fall-through); pop occurs when valid&ready.
REQ-016 SHALL run a read FSM with states R_IDLE, R_ACK, R_DROP: R_IDLE->R_ACK when read_req_i=1 and target readable; R_ACK->R_DROP unconditionally; R_DROP->R_IDLE when read_req_i=0.
REQ-017 SHALL assert read_ack_o only in R_ACK (exactly one cycle), registering dout_o on the R_IDLE->R_ACK transition; read latency 1 cycle from a readable sampled request.
REQ-018 SHALL treat channel c<NUM_CH as readable iff input FIFO c not empty, popping one entry on the R_IDLE->R_ACK edge; an empty channel stalls (no ack) until an entry arrives.
REQ-019 SHALL treat address NUM_CH as status port, always readable: dout_o[NUM_CH-1:0] = input-FIFO non-empty flags, dout_o[2*NUM_CH-1:NUM_CH] = output-FIFO full flags, remaining bits 0.
REQ-020 SHALL treat read addresses >NUM_CH as always readable returning all-zero data.
REQ-021 SHALL run a write FSM with states W_IDLE, W_ACK, W_DROP, identical transitions to REQ-016 using write_req_i/write_ack_o.
REQ-022 SHALL treat channel c<NUM_CH as writable iff output FIFO c not full, pushing din_i on the W_IDLE->W_ACK edge; a full channel stalls until space frees.
REQ-023 SHALL treat write addresses >=NUM_CH as always writable, acking and discarding data.
REQ-024 SHALL allow ext push and core pop on the same input FIFO in one cycle (count unchanged), and core push and ext pop on the same output FIFO in one cycle; full/empty evaluated on pre-edge state.
REQ-025 SHALL allow read and write FSMs to progress independently and simultaneously, including to the same channel number.
REQ-026 SHALL sample address and data only on the IDLE->ACK edge; changes to them while stalled are honoured, changes after ack are ignored.

Reset
REQ-027 SHALL, when reset_i=1 at a clock edge, set both FSMs to IDLE, all FIFO counts and pointers to 0, read_ack_o=0, write_ack_o=0, dout_o=0, ext_in_ready_o=all ones, ext_out_valid_o=0, overriding any in-flight handshake or push/pop that cycle.
REQ-028 SHALL, after reset release with a request still held, treat it as a new request from IDLE.

Verification
REQ-029 Bench: ext pushes 0x1, 0x2 on ch1; core reads addr 1 twice -> read_ack_o pulses 1 cycle each, dout_o 0x1 then 0x2, FIFO empty after.
REQ-030 Bench: core reads addr 2 with ch2 empty for 5 cycles, then ext pushes 0x3AB -> no ack during stall, ack next cycle after push with dout_o=0x3AB.
REQ-031 Bench: write DEPTH words to addr 0 with ext_out_ready_i[0]=0 -> DEPTH acks, next write stalls; raise ready one cycle -> 0th word drained, stalled write acks next cycle.
REQ-032 Bench: ch0 in-FIFO nonempty, ch3 out-FIFO full, read addr NUM_CH (4) -> dout_o=0x81 (bit0 and bit7 set).
REQ-033 Bench: hold read_req_i high 4 cycles after ack -> exactly one pop and one ack; write addr 15 -> ack, no FIFO change.
REQ-034 Bench: assert reset_i during R_ACK with 3 entries queued -> next cycle read_ack_o=0, all counts 0, ext_in_ready_o=0xF.
